// File: rtl/qpp_read_addr_gen.sv
// ---------------------------------------------------------------------------
// qpp_read_addr_gen
//
// Read-side address generator for the turbo-code interleaver block memory.
// The write side fills the memory in natural order. This block then walks
// the read index i and emits the QPP-permuted address
//   pi(i) = (f1*i + f2*i^2) mod K
// with one address for each accepted handshake. Two block sizes are
// supported: K=1056 and K=6144.
//
// pi is computed recursively, so the datapath needs only add, compare and
// subtract:
//   pi(i+1) = pi(i) + g(i)    (mod K),  g(0) = f1 + f2
//   g(i+1)  = g(i)  + 2*f2    (mod K)
// pi and g always stay below K, so each update needs at most one
// conditional subtraction of K.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-low
//   start        in   1   begin a block (only honoured in IDLE)
//   block_size   in   1   0 = K 1056, 1 = K 6144 (sampled with start)
//   read_enable  in   1   downstream ready; accept = rd_valid & read_enable
//   rd_addr      out  13  permuted read address pi(i)
//   rd_valid     out  1   rd_addr is valid (READ state)
//   count        out  13  current read index i
//   busy         out  1   high while in READ
//   done         out  1   one-cycle pulse after the last address is accepted
// ---------------------------------------------------------------------------
module qpp_read_addr_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        block_size,
  input  logic        read_enable,
  output logic [12:0] rd_addr,
  output logic        rd_valid,
  output logic [12:0] count,
  output logic        busy,
  output logic        done
);

  // Block-size constants: K, g0 = f1 + f2, dg = 2*f2
  localparam logic [12:0] K_SMALL  = 13'd1056;
  localparam logic [12:0] G0_SMALL = 13'd83;
  localparam logic [12:0] DG_SMALL = 13'd132;
  localparam logic [12:0] K_LARGE  = 13'd6144;
  localparam logic [12:0] G0_LARGE = 13'd743;
  localparam logic [12:0] DG_LARGE = 13'd960;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        bs_q;
  logic [12:0] idx;
  logic [12:0] pi;
  logic [12:0] g;

  logic [12:0] k_sel;
  logic [12:0] dg_sel;
  logic [12:0] k_last;
  logic [12:0] pi_next;
  logic [12:0] g_next;

  // Addition modulo k. Both operands are already below k, so the 14-bit
  // sum is less than 2k and a single conditional subtract is enough.
  function automatic logic [12:0] mod_add(input logic [12:0] a,
                                          input logic [12:0] b,
                                          input logic [12:0] k);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) begin
      s = s - {1'b0, k};
    end
    return s[12:0];
  endfunction

  // The constants come from the latched block size, so a change on the
  // block_size input during a block has no effect.
  assign k_sel   = bs_q ? K_LARGE : K_SMALL;
  assign dg_sel  = bs_q ? DG_LARGE : DG_SMALL;
  assign k_last  = k_sel - 13'd1;
  assign pi_next = mod_add(pi, g, k_sel);
  assign g_next  = mod_add(g, dg_sel, k_sel);

  assign rd_addr = pi;
  assign count   = idx;

  // Control FSM and datapath registers. The status outputs are registered
  // next to the state, so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bs_q     <= 1'b0;
      idx      <= '0;
      pi       <= '0;
      g        <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bs_q     <= block_size;
            idx      <= '0;
            pi       <= '0;
            g        <= block_size ? G0_LARGE : G0_SMALL;
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          // rd_valid is high throughout READ, so read_enable alone marks
          // an accept.
          if (read_enable) begin
            if (idx == k_last) begin
              rd_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              idx <= idx + 13'd1;
              pi  <= pi_next;
              g   <= g_next;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rd_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qpp_read_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_qpp_read_addr_gen
//
// Self-checking bench for qpp_read_addr_gen. The first part is a short
// table of cycle-by-cycle vectors covering reset, start, stalls and
// ignored inputs. The second part runs full blocks with random
// backpressure and checks every address against the closed-form
// permutation (f1*i + f2*i^2) mod K.
// ---------------------------------------------------------------------------
module tb_qpp_read_addr_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        block_size = 1'b0;
  logic        read_enable = 1'b0;
  logic [12:0] rd_addr;
  logic        rd_valid;
  logic [12:0] count;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit rst_n;
    bit st;
    bit bs;
    bit re;
    bit e_valid;
    int e_addr;
    int e_count;
    bit e_busy;
    bit e_done;
  } vec_t;

  vec_t vecs[$];

  qpp_read_addr_gen dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .block_size  (block_size),
    .read_enable (read_enable),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance past one rising edge. Outputs are sampled 1 ns after the edge,
  // and new inputs are driven well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Closed-form QPP address; this is independent of the recursion in the DUT
  function automatic int qpp(input int i, input bit bs);
    longint k;
    longint f1;
    longint f2;
    longint li;
    k  = bs ? 64'd6144 : 64'd1056;
    f1 = bs ? 64'd263 : 64'd17;
    f2 = bs ? 64'd480 : 64'd66;
    li = i;
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset       = v.rst_n;
    start       = v.st;
    block_size  = v.bs;
    read_enable = v.re;
    step();
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_valid"}, rd_valid, 0);
    checkOutput({tag, "_addr"}, rd_addr, 0);
    checkOutput({tag, "_count"}, count, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Run one block of block size bs. read_enable is high with probability
  // duty percent. Optional extras:
  //   ignoreAt  - pulse start and flip block_size at that index
  //   stallLast - hold read_enable low for this many cycles on the last index
  //   resetAt   - assert reset at that index and abandon the block
  task automatic runBlock(input bit bs, input int duty, input int ignoreAt,
                          input int stallLast, input int resetAt,
                          output int lastAddr);
    int k;
    int idx;
    int cycles;
    int stalled;
    int uniq;
    bit ignoreDone;
    bit re;
    bit seen[6144];
    k = bs ? 6144 : 1056;
    idx = 0;
    cycles = 0;
    stalled = 0;
    uniq = 0;
    ignoreDone = 1'b0;
    lastAddr = -1;
    foreach (seen[j]) seen[j] = 1'b0;

    reset = 1'b1;
    start = 1'b1;
    block_size = bs;
    read_enable = 1'b0;
    step();
    start = 1'b0;

    while (idx < k) begin
      if (cycles > 4 * k + 200) begin
        total++;
        bad++;
        $display("[TB] FAIL block_timeout: got idx %0d expected %0d", idx, k);
        break;
      end
      // If the address or count moved during a stall, it no longer
      // matches the unchanged model index.
      checkOutput("rd_valid", rd_valid, 1);
      checkOutput("rd_addr", rd_addr, qpp(idx, bs));
      checkOutput("count", count, idx);
      checkOutput("busy", busy, 1);
      checkOutput("done_early", done, 0);

      if (idx == resetAt) begin
        reset = 1'b0;
        read_enable = 1'b1;
        step();
        reset = 1'b1;
        read_enable = 1'b0;
        checkIdleZero("midreset");
        return;
      end

      if (idx == k - 1) lastAddr = int'(rd_addr);

      if (stallLast > 0 && idx == k - 1 && stalled < stallLast) begin
        re = 1'b0;
        stalled++;
      end else begin
        re = ($urandom_range(99) < duty);
      end

      if (idx == ignoreAt && !ignoreDone) begin
        start = 1'b1;
        block_size = ~bs;
        ignoreDone = 1'b1;
      end

      read_enable = re;
      if (re && rd_addr < 13'd6144) begin
        if (!seen[rd_addr]) uniq++;
        seen[rd_addr] = 1'b1;
      end
      step();
      start = 1'b0;
      cycles++;
      if (re) idx++;
    end

    // The last address was accepted at the previous edge
    read_enable = 1'b0;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_valid", rd_valid, 0);
    checkOutput("done_busy", busy, 0);
    step();
    checkOutput("idle_done", done, 0);
    checkOutput("idle_valid", rd_valid, 0);
    checkOutput("perm_unique", uniq, k);
    if (duty >= 100 && stallLast == 0) checkOutput("valid_cycles", cycles, k);
  endtask

  initial begin
    int last;
    $display("[TB] qpp_read_addr_gen bench start");

    //                rst st bs re | valid addr  count busy done
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0,    0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,    0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0,    0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0,    0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 83,   1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 298,  2, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 298,  2, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 645,  3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,    0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0,    0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 743,  1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2446, 2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,    0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0,    0, 1'b0, 1'b0});

    foreach (vecs[n]) begin
      applyStimulus(vecs[n]);
      checkOutput($sformatf("vec%0d_valid", n), rd_valid, vecs[n].e_valid);
      checkOutput($sformatf("vec%0d_addr", n), rd_addr, vecs[n].e_addr);
      checkOutput($sformatf("vec%0d_count", n), count, vecs[n].e_count);
      checkOutput($sformatf("vec%0d_busy", n), busy, vecs[n].e_busy);
      checkOutput($sformatf("vec%0d_done", n), done, vecs[n].e_done);
    end

    // Small block with no stalls
    runBlock(1'b0, 100, -1, 0, -1, last);
    checkOutput("last_small", last, 49);

    // Large block with no stalls
    runBlock(1'b1, 100, -1, 0, -1, last);
    checkOutput("last_large", last, 217);

    // Backpressure at about 50% duty
    runBlock(1'b0, 50, -1, 0, -1, last);
    checkOutput("last_small_bp", last, 49);

    // start and block_size toggled mid-block are ignored
    runBlock(1'b0, 100, 100, 0, -1, last);
    checkOutput("last_small_ign", last, 49);

    // Reset at index 500, then a fresh block restarts from address 0
    runBlock(1'b0, 70, -1, 0, 500, last);

    // Stall on the last index, then start again back-to-back
    runBlock(1'b0, 100, -1, 10, -1, last);
    checkOutput("last_small_stall", last, 49);
    runBlock(1'b1, 50, -1, 0, -1, last);
    checkOutput("last_large_bp", last, 217);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
